// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory address/data port, ID-stage control
// inputs and the IF/ID pipeline register outputs.
interface if_fetch_unit_if;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_addr_err;
    logic [31:0] fetch_count;

    // The fetch unit drives the memory address and the IF/ID register.
    modport master (
        input  im_instr, stall, redirect_valid, redirect_pc, flush,
        output im_pc, id_valid, id_instr, id_pc, id_pc8, id_addr_err, fetch_count
    );

    modport slave (
        output im_instr, stall, redirect_valid, redirect_pc, flush,
        input  im_pc, id_valid, id_instr, id_pc, id_pc8, id_addr_err, fetch_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory and
// loads the IF/ID register, with stall, delay-slot redirect and flush.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    if_fetch_unit_if.master bus
);
    localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        addr_bad;
    logic [31:0] fetched_word;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_addr_err;
    logic [31:0] fetch_count;

    // A redirect only changes the next PC; the word in IF is still captured as the delay slot.
    assign next_pc      = bus.redirect_valid ? bus.redirect_pc : pc + 32'd4;
    assign addr_bad     = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc > PC_LAST);
    assign fetched_word = addr_bad ? NOP_WORD : bus.im_instr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= PC_RESET;
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc       <= 32'd0;
            id_pc8      <= 32'd0;
            id_addr_err <= 1'b0;
            fetch_count <= 32'd0;
        end else if (bus.flush) begin
            pc          <= next_pc;
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_addr_err <= 1'b0;
        end else if (!bus.stall) begin
            pc          <= next_pc;
            id_valid    <= 1'b1;
            id_instr    <= fetched_word;
            id_pc       <= pc;
            id_pc8      <= pc + 32'd8;
            id_addr_err <= addr_bad;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign bus.im_pc       = pc;
    assign bus.id_valid    = id_valid;
    assign bus.id_instr    = id_instr;
    assign bus.id_pc       = id_pc;
    assign bus.id_pc8      = id_pc8;
    assign bus.id_addr_err = id_addr_err;
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized control traffic against a behavioural model.
module tb_if_fetch_unit;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_LAST  = 32'h0000_6ffc;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .PC_RESET (PC_RESET),
        .IM_WORDS (IM_WORDS),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] addr);
        case (addr)
            32'h3000: return 32'h3401_ffff;
            32'h3004: return 32'h1021_0003;
            32'h3008: return 32'h3402_ffff;
            default:  return {addr[15:0] ^ 16'h5a5a, ~addr[15:0]};
        endcase
    endfunction

    assign bus.im_instr = romWord(bus.im_pc);

    // Reference state: the architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc8, m_count;
    logic        m_valid, m_err, m_ready;

    initial m_ready = 1'b0;

    always @(posedge clk) begin
        logic [31:0] target;
        logic        bad;
        target = bus.redirect_valid ? bus.redirect_pc : m_pc + 32'd4;
        bad    = (m_pc % 4 != 0) || (m_pc < PC_RESET) || (m_pc > PC_LAST);
        if (reset == 1'b0) begin
            m_pc = PC_RESET; m_valid = 0; m_err = 0; m_instr = NOP_WORD;
            m_idpc = 0; m_idpc8 = 0; m_count = 0;
        end else if (bus.flush) begin
            m_valid = 0; m_instr = NOP_WORD; m_err = 0; m_pc = target;
        end else if (!bus.stall) begin
            m_valid = 1; m_err = bad;
            m_instr = bad ? NOP_WORD : romWord(m_pc);
            m_idpc = m_pc; m_idpc8 = m_pc + 32'd8;
            m_count = m_count + 1; m_pc = target;
        end
        m_ready = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every negative edge the whole DUT output set is compared to the model.
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("model.im_pc", bus.im_pc, m_pc);
            checkOutput("model.id_valid", 32'(bus.id_valid), 32'(m_valid));
            checkOutput("model.id_instr", bus.id_instr, m_instr);
            checkOutput("model.id_pc", bus.id_pc, m_idpc);
            checkOutput("model.id_pc8", bus.id_pc8, m_idpc8);
            checkOutput("model.id_addr_err", 32'(bus.id_addr_err), 32'(m_err));
            checkOutput("model.fetch_count", bus.fetch_count, m_count);
        end
    end

    task automatic applyStimulus(input logic rst, input logic stl, input logic rv,
                                 input logic [31:0] rpc, input logic fl);
        reset              = rst;
        bus.stall          = stl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.flush          = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.flush = 0;

        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst.im_pc", bus.im_pc, 32'h3000);
        checkOutput("rst.id_valid", 32'(bus.id_valid), 0);
        checkOutput("rst.fetch_count", bus.fetch_count, 0);

        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("first.id_pc", bus.id_pc, 32'h3000);
        checkOutput("first.id_instr", bus.id_instr, 32'h3401_ffff);
        checkOutput("first.id_pc8", bus.id_pc8, 32'h3008);
        checkOutput("first.count", bus.fetch_count, 1);
        checkOutput("first.im_pc", bus.im_pc, 32'h3004);

        applyStimulus(1, 0, 1, 32'h3014, 0);
        checkOutput("redir.delay_slot_pc", bus.id_pc, 32'h3004);
        checkOutput("redir.delay_slot_instr", bus.id_instr, 32'h1021_0003);
        checkOutput("redir.id_pc8", bus.id_pc8, 32'h300c);
        checkOutput("redir.im_pc", bus.im_pc, 32'h3014);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("redir.target_pc", bus.id_pc, 32'h3014);
        checkOutput("redir.im_pc_next", bus.im_pc, 32'h3018);

        applyStimulus(1, 0, 1, 32'h3008, 0);
        repeat (2) begin
            applyStimulus(1, 1, 1, 32'h3020, 0);
            checkOutput("stall.im_pc", bus.im_pc, 32'h3008);
            checkOutput("stall.id_pc", bus.id_pc, 32'h3018);
            checkOutput("stall.count", bus.fetch_count, 4);
        end
        applyStimulus(1, 0, 1, 32'h3020, 0);
        checkOutput("unstall.id_pc", bus.id_pc, 32'h3008);
        checkOutput("unstall.id_instr", bus.id_instr, 32'h3402_ffff);
        checkOutput("unstall.im_pc", bus.im_pc, 32'h3020);
        checkOutput("unstall.count", bus.fetch_count, 5);

        applyStimulus(1, 0, 1, 32'h300c, 0);
        applyStimulus(1, 1, 0, 0, 1);
        checkOutput("flush.id_valid", 32'(bus.id_valid), 0);
        checkOutput("flush.id_instr", bus.id_instr, 0);
        checkOutput("flush.im_pc", bus.im_pc, 32'h3010);
        checkOutput("flush.count", bus.fetch_count, 6);

        applyStimulus(1, 0, 1, 32'h3002, 0);
        applyStimulus(1, 0, 1, 32'h7000, 0);
        checkOutput("err1.id_pc", bus.id_pc, 32'h3002);
        checkOutput("err1.id_addr_err", 32'(bus.id_addr_err), 1);
        checkOutput("err1.id_instr", bus.id_instr, 0);
        checkOutput("err1.id_valid", 32'(bus.id_valid), 1);
        applyStimulus(1, 0, 1, 32'h6ffc, 0);
        checkOutput("err2.id_pc", bus.id_pc, 32'h7000);
        checkOutput("err2.id_addr_err", 32'(bus.id_addr_err), 1);
        checkOutput("err2.id_instr", bus.id_instr, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("last.id_pc", bus.id_pc, 32'h6ffc);
        checkOutput("last.id_addr_err", 32'(bus.id_addr_err), 0);
        checkOutput("last.id_valid", 32'(bus.id_valid), 1);

        applyStimulus(0, 1, 1, 32'h4000, 0);
        checkOutput("rst2.im_pc", bus.im_pc, 32'h3000);
        checkOutput("rst2.id_valid", 32'(bus.id_valid), 0);
        checkOutput("rst2.count", bus.fetch_count, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 5))
                0:       rpc = $urandom;
                1:       rpc = 32'hffff_fffc;
                2:       rpc = PC_LAST;
                default: rpc = PC_RESET + 32'($urandom_range(0, IM_WORDS - 1)) * 4;
            endcase
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, rpc, $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator. Owns the PC register and drives the instruction memory's address port.
- The memory's instruction word returns combinationally in the same cycle; this block registers it into the IF/ID pipeline register for decode.
- Handles decode stall, branch/jump redirect (MIPS delay-slot semantics: the instruction in IF at redirect time is kept), pipeline flush, and a fetched-instruction counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base of instruction space.
- IM_WORDS, 4096, instruction memory depth in words; valid PC range is PC_RESET .. PC_RESET+4*IM_WORDS-4.
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on a bubble or address error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- im_pc  output  32  fetch address to instruction memory; equals the internal pc register (combinational).
- im_instr  input  32  instruction word returned combinationally for im_pc.
- stall  input  1  decode stall; hold pc and IF/ID.
- redirect_valid  input  1  branch/jump taken, issued from ID.
- redirect_pc  input  32  target PC.
- flush  input  1  insert a bubble into IF/ID.
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  registered instruction.
- id_pc  output  32  PC of id_instr.
- id_pc8  output  32  id_pc+8 (link address for jal/jalr).
- id_addr_err  output  1  fetched PC was misaligned or out of range.
- fetch_count  output  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (reset==0 at the rising edge):
  - pc <= PC_RESET.
  - id_valid, id_addr_err <= 0.
  - id_instr <= NOP_WORD.
  - id_pc, id_pc8, fetch_count <= 0.
  - Reset overrides all other inputs, including mid-stall and mid-redirect.
- addr_bad (combinational): pc[1:0]!=0, or pc<PC_RESET, or pc>PC_RESET+4*IM_WORDS-4. Compute with 32-bit unsigned compares.
- fetched_word = addr_bad ? NOP_WORD : im_instr.
- Per-edge priority, highest first, when reset==1:
  1. flush=1:
     - IF/ID <= bubble: id_valid=0, id_instr=NOP_WORD, id_addr_err=0; id_pc and id_pc8 unchanged.
     - pc advances as if stall=0: redirect_pc if redirect_valid, else pc+4.
     - flush overrides stall.
  2. stall=1:
     - pc and all IF/ID outputs hold.
     - redirect_valid is ignored; ID keeps asserting it until the stall clears.
     - fetch_count holds.
  3. Otherwise:
     - IF/ID <= {id_valid=1, id_instr=fetched_word, id_pc=pc, id_pc8=pc+8, id_addr_err=addr_bad}.
     - pc <= redirect_valid ? redirect_pc : pc+4.
     - fetch_count <= fetch_count+1.
- Delay slot: a redirect does not squash the instruction currently in IF; it is captured normally as the delay slot.
- Latency:
  - Instruction at pc appears on id_* one edge after the cycle it is fetched.
  - First valid id_* appears on the first edge after reset deasserts, with id_pc=PC_RESET.
- Arithmetic: pc+4 and pc+8 are modulo 2^32; wrap past 32'hFFFF_FFFC yields 0, which is flagged by addr_bad, with no special casing.
- An addr-error fetch still counts as valid (id_valid=1), so ID can raise AdEL. The pc keeps advancing unless redirected.
- redirect_pc is used unmodified. Misaligned targets are reported via id_addr_err on the following fetch.
- fetch_count wraps 32'hFFFF_FFFF -> 0.
- No combinational path from stall, redirect_* or flush to im_pc.

Test Plan:
- Reset held low 3 cycles, then released; im_instr = ROM {3401ffff, 10210003, 3402ffff}:
  - im_pc = 3000, 3004, 3008 on successive cycles.
  - id_pc = 3000, 3004; id_instr = 3401ffff, 10210003; id_pc8 = 3008, 300c; fetch_count = 1, 2.
- Redirect: at pc=3004 assert redirect_valid with redirect_pc=3014 for one cycle:
  - Next id_pc = 3004 (delay slot kept).
  - im_pc sequence 3004 -> 3014 -> 3018; no instruction from 3008 ever reaches ID.
- Stall: assert stall 2 cycles at pc=3008, with redirect_valid=1 during the stall:
  - im_pc stays 3008; id_* and fetch_count frozen.
  - redirect is honoured only on the first non-stall edge.
- Flush together with stall, at pc=300c:
  - id_valid=0 and id_instr=0 next cycle; pc moves to 3010; fetch_count unchanged.
- Address error: redirect_pc=3002, then redirect_pc=7000:
  - Each fetch gives id_addr_err=1, id_instr=0, id_valid=1, id_pc=3002 / 7000 respectively.
  - Then redirect_pc=6ffc gives id_addr_err=0.
- Reset asserted while stall=1 and redirect_valid=1:
  - Next edge: pc=3000, id_valid=0, fetch_count=0.
